// File: rtl/gf2m_b409_pkg.sv
// Shared constants and types for the GF(2^409) reducer, field polynomial x^409 + x^87 + 1.
package gf2m_b409_pkg;

    localparam int unsigned M      = 409;
    localparam int unsigned K      = 87;
    localparam int unsigned PROD_W = 2 * M - 1;
    localparam int unsigned SHIFT  = M - K;

    typedef enum logic [1:0] {
        StIdle,
        StFold,
        StDone
    } state_e;

    // Number of fold cycles needed to clear the 408 high-order product bits.
    function automatic int unsigned nfold(input int unsigned fold);
        return (PROD_W - M + fold - 1) / fold;
    endfunction

endpackage

// File: rtl/gf2m_b409_reducer_if.sv
// Valid/ready handshake bundle for the product input and reduced-element output.
interface gf2m_b409_reducer_if;
    import gf2m_b409_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [M-1:0]      out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/gf2m_fold_slice.sv
// One combinational fold step: clears chunk k of the high half, XORing it back via
// x^409 = x^87 + 1.
module gf2m_fold_slice
    import gf2m_b409_pkg::*;
#(
    parameter int unsigned FOLD = 64,
    parameter int unsigned CntW = 3
) (
    input  logic [PROD_W-1:0] r_i,
    input  logic [CntW-1:0]   k_i,
    output logic [PROD_W-1:0] r_o
);

    int                hi;
    int                lo;
    logic [PROD_W-1:0] mask;
    logic [PROD_W-1:0] chunk;

    always_comb begin
        hi = int'(PROD_W) - 1 - int'(k_i) * int'(FOLD);
        lo = hi - int'(FOLD) + 1;
        if (lo < int'(M)) begin
            lo = int'(M);
        end
        for (int i = 0; i < int'(PROD_W); i++) begin
            mask[i] = (i >= lo) && (i <= hi);
        end
    end

    // Shifted targets always land below lo, so the chunk never feeds back into itself.
    assign chunk = r_i & mask;
    assign r_o   = (r_i & ~chunk) ^ (chunk >> SHIFT) ^ (chunk >> M);

endmodule

// File: rtl/gf2m_b409_reducer.sv
// Sequential GF(2^409) reducer: accepts an 817-bit product, folds FOLD bits per cycle,
// then holds the 409-bit result until the consumer takes it.
module gf2m_b409_reducer
    import gf2m_b409_pkg::*;
#(
    parameter int unsigned FOLD = 64
) (
    input logic              clk,
    input logic              rst_n,
    gf2m_b409_reducer_if.slave bus
);

    localparam int unsigned NFold = nfold(FOLD);
    localparam int unsigned CntW  = (NFold > 1) ? $clog2(NFold) : 1;

    state_e            state_q;
    logic [PROD_W-1:0] r_q;
    logic [PROD_W-1:0] r_fold;
    logic [CntW-1:0]   cnt_q;
    logic              in_ready_q;
    logic              out_valid_q;

    gf2m_fold_slice #(
        .FOLD (FOLD),
        .CntW (CntW)
    ) u_slice (
        .r_i (r_q),
        .k_i (cnt_q),
        .r_o (r_fold)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? r_q[M-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            r_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid && in_ready_q) begin
                        r_q        <= bus.in_data;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StFold;
                    end
                end
                StFold: begin
                    r_q   <= r_fold;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(NFold - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/gf2m_b409_reducer.md
Name: gf2m_b409_reducer

Overview:
- Sequential modular reducer for GF(2^409) with field polynomial f(x) = x^409 + x^87 + 1 (NIST B-409).
- Consumes the 817-bit unreduced polynomial product from the combinational 409-bit overlap-free Karatsuba multiplier.
- Returns the 409-bit canonical field element.
- Sits directly downstream of the multiplier. Valid/ready handshake on both sides.
- Folds FOLD high-order bits per cycle, trading latency for area.

Parameters:
- FOLD, 64, bits folded per cycle; legal range 1..321; reducer cycle count NFOLD = ceil(408/FOLD).

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  product word valid
- in_ready  out  1  reducer can accept a product
- in_data  in  817  unreduced product c(x), bit i = coeff of x^i
- out_valid  out  1  reduced result valid
- out_ready  in  1  consumer accepts result
- out_data  out  409  c(x) mod f(x), bit i = coeff of x^i

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - state=IDLE, work register r=0, fold counter=0.
  - in_ready=1, out_valid=0, out_data=0.
  - Reset asserted mid-fold or in DONE aborts the operation; the partial result is discarded and never emitted.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid && in_ready: r <= in_data, cnt <= 0, go FOLD.
  - FOLD: in_ready=0, out_valid=0. Each cycle fold one chunk, cnt++. When cnt reaches NFOLD-1 the current fold is the last; go DONE.
  - DONE: out_valid=1, out_data=r[408:0], stable until handshake. On out_ready: go IDLE. A new input is not accepted in the same cycle; in_ready=0 in DONE.
- Fold step k (k = 0..NFOLD-1):
  - Chunk covers bit positions hi = 816 - k*FOLD down to lo = max(409, hi-FOLD+1).
  - For each set bit i in [lo, hi]: clear r[i], r[i-322] ^= 1, r[i-409] ^= 1. Both updates use the identity x^409 ≡ x^87 + 1.
  - All bits in a chunk are processed in parallel as pure XOR; no carries.
  - Targets i-322 can land at ≥409 only below lo, since FOLD ≤ 321. They are cleared by later chunks because processing is top-down.
  - After the final fold, r[816:409] == 0. This is an internal invariant; the bench checks it through a hierarchical probe.
- Latency: input accepted at edge E0; folds at edges E1..E_NFOLD; out_valid=1 in the cycle after E_NFOLD.
  - Default FOLD=64: NFOLD=7, so out_valid rises 7 cycles after acceptance.
  - Throughput: one result per NFOLD+2 cycles minimum.
- Boundary conditions:
  - Input degree < 409: still runs all NFOLD cycles (fixed latency, no early exit); output equals in_data[408:0].
  - in_valid held during FOLD/DONE is ignored, not queued.
  - out_ready held high before out_valid has no effect.
  - in_data is sampled only on the accept edge; later changes do not affect the result.

Decomposition:
- Package gf2m_b409_pkg holds: M=409, K=87, PROD_W=2*M-1=817, SHIFT=M-K=322, the state enum type {IDLE, FOLD, DONE}, and function nfold(FOLD).
- Sub-module gf2m_fold_slice (combinational):
  - Inputs: 817-bit r and chunk index k.
  - Output: the folded 817-bit r per the fold-step rule.
  - The top level instantiates one slice and muxes its output into r during FOLD.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles -> in_ready=1, out_valid=0, out_data=0; assert rst_n=0 mid-FOLD -> same values immediately, no out_valid afterwards.
- in_data = x^409 (only bit 409 set) -> out_data has bits 87 and 0 set only; out_valid rises exactly 7 cycles after accept (FOLD=64).
- in_data = x^816 -> out_data bits {407,172,85} set only. in_data = x^731 -> bits {322,87,0} set only.
- in_data with upper 408 bits zero, low 409 bits = 0x...ABAB pattern from the multiplier bench -> out_data equals input low bits; all-zero input -> zero output.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0; then a one-cycle out_ready -> IDLE next cycle with in_ready=1.
- Random: 1000 random 409-bit a, b pairs through the Karatsuba multiplier into this block, random ready stalls -> each output matches a reference bitwise shift-XOR modular multiply, in order, none lost or duplicated.
